// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: one outstanding word read to instruction memory,
// a small {inst, pc} FIFO toward decode, and redirect-driven flush/refetch.
module inst_fetch_unit #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
  parameter int                   DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 mem_read,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic                 mem_ready,
  input  logic [WORD_SIZE-1:0] mem_data,
  output logic                 inst_valid,
  output logic [WORD_SIZE-1:0] inst,
  output logic [WORD_SIZE-1:0] inst_pc,
  input  logic                 inst_ready,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ALMOST = CNT_W'(DEPTH - 1);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] STALL   = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  typedef struct packed {
    logic [WORD_SIZE-1:0] word;
    logic [WORD_SIZE-1:0] pc;
  } fetchEntry_t;

  logic [1:0]           state;
  logic [WORD_SIZE-1:0] fetchPc;
  logic [WORD_SIZE-1:0] discardAddr;
  fetchEntry_t          fifoMem [DEPTH];
  logic [PTR_W-1:0]     rdPtr, wrPtr;
  logic [CNT_W-1:0]     count;
  logic                 push, pop;

  // mem_read depends on state alone; the old address is replayed while discarding
  assign mem_read   = (state != STALL);
  assign mem_addr   = (state == DISCARD) ? discardAddr : fetchPc;
  assign inst_valid = (count != '0);
  assign inst       = fifoMem[rdPtr].word;
  assign inst_pc    = fifoMem[rdPtr].pc;

  assign push = (state == RUN) && mem_ready && !redirect;
  assign pop  = inst_valid && inst_ready && !redirect;

  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= '{word: mem_data, pc: fetchPc};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      fetchPc     <= RESET_PC;
      discardAddr <= RESET_PC;
      rdPtr       <= '0;
      wrPtr       <= '0;
      count       <= '0;
    end else if (redirect) begin
      fetchPc <= redirect_pc;
      rdPtr   <= '0;
      wrPtr   <= '0;
      count   <= '0;
      // A request still open must be waited out so its data can be dropped
      if (state == STALL || mem_ready) state <= RUN;
      else                             state <= DISCARD;
      if (state == RUN) discardAddr <= fetchPc;
    end else begin
      if (push) begin
        wrPtr   <= wrPtr + 1'b1;
        fetchPc <= fetchPc + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;

      case (state)
        RUN:     if (push && !pop && count == ALMOST) state <= STALL;
        STALL:   if (count != FULL) state <= RUN;
        DISCARD: if (mem_ready) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: the model is "sequential PCs from the last
// reset/redirect target, data = memory image"; a negedge monitor pops and compares.
module tb_inst_fetch_unit;
  localparam logic [15:0] RST_PC = 16'h0000;
  localparam int          WIN    = 64;

  logic        clk = 1'b0, reset = 1'b1;
  logic        mem_ready = 1'b0, inst_ready = 1'b0, redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        mem_read, inst_valid;
  logic [15:0] mem_addr, mem_data, inst, inst_pc;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return a + 16'hA000;
  endfunction

  assign mem_data = memWord(mem_addr);
  always #5 clk = ~clk;

  inst_fetch_unit #(.WORD_SIZE(16), .RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  typedef struct { logic [15:0] pc; logic [15:0] word; } exp_t;
  exp_t expQ[$];
  exp_t monE;
  int checks = 0, errors = 0, memDone = 0, accepts = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Expected stream after a reset or redirect: consecutive PCs, wrapping at 16 bits
  function automatic void loadQ(input logic [15:0] pc);
    exp_t e;
    expQ.delete();
    for (int i = 0; i < WIN; i++) begin
      e.pc   = pc + 16'(i);
      e.word = memWord(e.pc);
      expQ.push_back(e);
    end
  endfunction

  logic        pReset = 1'b1, pRedir = 1'b0, pRead = 1'b0, pMemRdy = 1'b0;
  logic        pValid = 1'b0, pInstRdy = 1'b0;
  logic [15:0] pAddr = '0, pInst = '0, pPc = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (!pReset) begin
        if (pRedir) check("flush", inst_valid, 0);
        if (pRead && !pMemRdy) check("mem_hold", {mem_read, mem_addr}, {1'b1, pAddr});
        if (pValid && !pInstRdy && !pRedir)
          check("head_hold", {inst_valid, inst, inst_pc}, {1'b1, pInst, pPc});
      end
      if (inst_valid && inst_ready && !redirect) begin
        accepts++;
        if (expQ.size() == 0) check("sb_underflow", 0, 1);
        else begin
          monE = expQ.pop_front();
          check("inst_pc", inst_pc, monE.pc);
          check("inst", inst, monE.word);
        end
      end
      if (mem_read && mem_ready) memDone++;
    end
    pReset = reset; pRedir = redirect; pRead = mem_read; pMemRdy = mem_ready;
    pValid = inst_valid; pInstRdy = inst_ready;
    pAddr = mem_addr; pInst = inst; pPc = inst_pc;
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic doReset(input int n);
    reset = 1'b1; redirect = 1'b0; loadQ(RST_PC);
    step(n);
    reset = 1'b0;
  endtask

  task automatic doRedirect(input logic [15:0] pc);
    redirect = 1'b1; redirect_pc = pc; loadQ(pc);
    step(1);
    redirect = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int m0, a0, since;
    // Reset and zero-wait streaming
    mem_ready = 1'b1; inst_ready = 1'b1;
    loadQ(RST_PC);
    step(1);
    check("reset_state", {inst_valid, mem_read, mem_addr}, {1'b0, 1'b1, RST_PC});
    step(1);
    reset = 1'b0;
    step(1);
    check("first_valid", {inst_valid, inst_pc, inst}, {1'b1, 16'h0000, 16'hA000});
    for (int i = 0; i < 16; i++) begin
      step(1);
      check("throughput", inst_valid, 1);
    end

    // Memory answers every 4th cycle
    mem_ready = 1'b0; step(2);
    m0 = memDone; a0 = accepts;
    for (int i = 0; i < 24; i++) begin
      mem_ready = (i % 4 == 3);
      step(1);
    end
    mem_ready = 1'b0; step(2);
    check("wait_returns", memDone - m0, 6);
    check("wait_pulses", accepts - a0, memDone - m0);

    // Backpressure fills the buffer and stalls fetch
    inst_ready = 1'b0; mem_ready = 1'b1;
    doReset(2);
    m0 = memDone;
    step(10);
    check("bp_completions", memDone - m0, 2);
    check("bp_stall", mem_read, 0);
    check("bp_head", {inst_valid, inst_pc}, {1'b1, 16'h0000});
    inst_ready = 1'b1;
    for (int k = 0; k < 10 && !mem_read; k++) step(1);
    check("bp_resume", {mem_read, mem_addr}, {1'b1, 16'h0002});

    // Redirect while a request is outstanding
    mem_ready = 1'b0;
    doRedirect(16'h0005);
    mem_ready = 1'b1; step(1); mem_ready = 1'b0;
    check("inflight_req5", {mem_read, mem_addr}, {1'b1, 16'h0005});
    doRedirect(16'h0040);
    check("discard_hold", {inst_valid, mem_read, mem_addr}, {1'b0, 1'b1, 16'h0005});
    step(1);
    mem_ready = 1'b1; step(1); mem_ready = 1'b0;
    check("inflight_next", {mem_read, mem_addr}, {1'b1, 16'h0040});
    mem_ready = 1'b1; step(6);

    // Redirect coinciding with mem_ready and a pop
    check("sim_pre", inst_valid, 1);
    doRedirect(16'h1234);
    check("sim_empty", inst_valid, 0);
    check("sim_addr", {mem_read, mem_addr}, {1'b1, 16'h1234});
    step(1);
    check("sim_first", {inst_valid, inst_pc}, {1'b1, 16'h1234});

    // Address wrap
    a0 = accepts;
    doRedirect(16'hFFFF);
    step(6);
    check("wrap_count", (accepts - a0 >= 3), 1);

    // Randomized traffic
    since = 0;
    for (int i = 0; i < 3000; i++) begin
      mem_ready  = 1'($urandom_range(0, 1));
      inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1; loadQ(RST_PC); step(1); reset = 1'b0; since = 0;
      end else if (since >= 40 || $urandom_range(0, 19) == 0) begin
        doRedirect(16'($urandom)); since = 0;
      end else begin
        step(1); since++;
      end
    end
    mem_ready = 1'b0; inst_ready = 1'b1; step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
